// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for mem_port_arbiter.
//   arb_state_t   : arbiter FSM states
//   grant_t       : which requester owns (or last owned) the memory port
//   LINE_OFFSET_W : byte-offset width of an icache line at the default line size
//   line_offset_w : the same quantity for any LINE_WORDS value
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IC_BURST,
    DM_ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    GRANT_IC,
    GRANT_DM
  } grant_t;

  localparam int LINE_WORDS_DEF = 4;
  localparam int LINE_OFFSET_W  = $clog2(LINE_WORDS_DEF) + 2;

  function automatic int line_offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating event counter for the arbiter's performance outputs.
//   clk   : clock
//   rst_n : async active-low clear
//   inc   : count this cycle
//   count : current value, sticks at all-ones
module mem_arb_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between the icache
// refill engine (LINE_WORDS-beat bursts) and the data-memory stage (single
// beats). Bursts are never preempted; every transaction ends with a DONE
// state followed by a one-cycle done pulse.
//
// Ports:
//   clk_i, reset_n_i          : clock, async active-low reset
//   ic_req_i/ic_addr_i        : refill request and line address
//   ic_rvalid_o/rdata/beat    : refill beat stream
//   ic_done_o                 : pulse after the last refill beat
//   dm_req_i/we/addr/wdata/be : data access request
//   dm_rdata_o/dm_done_o      : load data and completion pulse
//   mem_*                     : registered memory port, ack completes a beat
//
// Build option: define MEM_ARB_PERF_EN to add ic_wait_cycles_o,
// dm_wait_cycles_o and conflict_cnt_o saturating counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          ic_req_i,
  input  logic [ADDR_W-1:0]             ic_addr_i,
  output logic                          ic_rvalid_o,
  output logic [31:0]                   ic_rdata_o,
  output logic [$clog2(LINE_WORDS)-1:0] ic_beat_o,
  output logic                          ic_done_o,
  input  logic                          dm_req_i,
  input  logic                          dm_we_i,
  input  logic [ADDR_W-1:0]             dm_addr_i,
  input  logic [31:0]                   dm_wdata_i,
  input  logic [3:0]                    dm_be_i,
  output logic [31:0]                   dm_rdata_o,
  output logic                          dm_done_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_be_o,
  input  logic                          mem_ack_i,
  input  logic [31:0]                   mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]                   ic_wait_cycles_o,
  output logic [31:0]                   dm_wait_cycles_o,
  output logic [31:0]                   conflict_cnt_o
`endif
);

  localparam int OFF_W  = line_offset_w(LINE_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  arb_state_t        state, state_d;
  grant_t            owner, owner_d;
  grant_t            last_grant, last_grant_d;
  logic [BEAT_W-1:0] beat, beat_d;

  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic [3:0]        mem_be_d;
  logic              ic_rvalid_d, ic_done_d, dm_done_d;
  logic [31:0]       ic_rdata_d, dm_rdata_d;
  logic [BEAT_W-1:0] ic_beat_d;

  // Line offset bits of the refill address are deliberately dropped.
  logic unused_ic_off;
  assign unused_ic_off = ^ic_addr_i[OFF_W-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      owner       <= GRANT_IC;
      last_grant  <= GRANT_DM;   // icache wins the first tie
      beat        <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      ic_rvalid_o <= 1'b0;
      ic_rdata_o  <= '0;
      ic_beat_o   <= '0;
      ic_done_o   <= 1'b0;
      dm_done_o   <= 1'b0;
      dm_rdata_o  <= '0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      last_grant  <= last_grant_d;
      beat        <= beat_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      mem_be_o    <= mem_be_d;
      ic_rvalid_o <= ic_rvalid_d;
      ic_rdata_o  <= ic_rdata_d;
      ic_beat_o   <= ic_beat_d;
      ic_done_o   <= ic_done_d;
      dm_done_o   <= dm_done_d;
      dm_rdata_o  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_grant_d = last_grant;
    beat_d       = beat;
    mem_req_d    = mem_req_o;
    mem_we_d     = mem_we_o;
    mem_addr_d   = mem_addr_o;
    mem_wdata_d  = mem_wdata_o;
    mem_be_d     = mem_be_o;
    ic_rvalid_d  = 1'b0;
    ic_rdata_d   = ic_rdata_o;
    ic_beat_d    = ic_beat_o;
    ic_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    dm_rdata_d   = dm_rdata_o;

    case (state)
      IDLE: begin
        // On a tie the requester that did not go last wins.
        if (ic_req_i && (!dm_req_i || last_grant == GRANT_DM)) begin
          state_d      = IC_BURST;
          owner_d      = GRANT_IC;
          last_grant_d = GRANT_IC;
          beat_d       = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {ic_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_wdata_d  = '0;
          mem_be_d     = 4'hF;
        end else if (dm_req_i) begin
          state_d      = DM_ACCESS;
          owner_d      = GRANT_DM;
          last_grant_d = GRANT_DM;
          mem_req_d    = 1'b1;
          mem_we_d     = dm_we_i;
          mem_addr_d   = dm_addr_i;
          mem_wdata_d  = dm_wdata_i;
          mem_be_d     = dm_be_i;
        end
      end
      IC_BURST: begin
        if (mem_ack_i) begin
          ic_rvalid_d = 1'b1;
          ic_rdata_d  = mem_rdata_i;
          ic_beat_d   = beat;
          if (beat == LAST_BEAT) begin
            state_d     = DONE;
            mem_req_d   = 1'b0;
            mem_addr_d  = '0;
            mem_be_d    = '0;
          end else begin
            // Base is line-aligned, so +4 never leaves the line.
            beat_d     = beat + BEAT_W'(1);
            mem_addr_d = mem_addr_o + ADDR_W'(4);
          end
        end
      end
      DM_ACCESS: begin
        if (mem_ack_i) begin
          if (!mem_we_o) dm_rdata_d = mem_rdata_i;
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_be_d    = '0;
        end
      end
      DONE: begin
        // The pulse lands in the following IDLE cycle; that cycle can
        // already decide the next grant.
        if (owner == GRANT_IC) ic_done_d = 1'b1;
        else                   dm_done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic ic_granted, dm_granted, conflict;
  assign ic_granted = (state != IDLE) && (owner == GRANT_IC);
  assign dm_granted = (state != IDLE) && (owner == GRANT_DM);
  assign conflict   = (state == IDLE) && ic_req_i && dm_req_i;

  mem_arb_perf_cnt #(.W(32)) u_ic_wait (
    .clk(clk_i), .rst_n(reset_n_i), .inc(ic_req_i && !ic_granted), .count(ic_wait_cycles_o)
  );
  mem_arb_perf_cnt #(.W(32)) u_dm_wait (
    .clk(clk_i), .rst_n(reset_n_i), .inc(dm_req_i && !dm_granted), .count(dm_wait_cycles_o)
  );
  mem_arb_perf_cnt #(.W(32)) u_conflict (
    .clk(clk_i), .rst_n(reset_n_i), .inc(conflict), .count(conflict_cnt_o)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LINE_WORDS=4). Memory model returns
// rdata = addr ^ 32'hA5A5_0000 and acks after ack_delay waiting cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        ic_req_i = 1'b0;
  logic [31:0] ic_addr_i = '0;
  logic        ic_rvalid_o;
  logic [31:0] ic_rdata_o;
  logic [1:0]  ic_beat_o;
  logic        ic_done_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [3:0]  dm_be_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] ic_wait_cycles_o, dm_wait_cycles_o, conflict_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  int wait_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rvalid_o(ic_rvalid_o),
    .ic_rdata_o(ic_rdata_o), .ic_beat_o(ic_beat_o), .ic_done_o(ic_done_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata_o),
    .dm_done_o(dm_done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
`ifdef MEM_ARB_PERF_EN
    , .ic_wait_cycles_o(ic_wait_cycles_o), .dm_wait_cycles_o(dm_wait_cycles_o),
    .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  assign mem_ack_i   = mem_req_o && (wait_cnt >= ack_delay);
  assign mem_rdata_i = mem_addr_o ^ 32'hA5A5_0000;

  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i)                   wait_cnt <= 0;
    else if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
    else                              wait_cnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    checks++; if ({ic_rvalid_o, ic_done_o, dm_done_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ic_rvalid_o, ic_done_o, dm_done_o}); end
    checks++; if (dm_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata_o); end
    reset_n_i = 1'b1;
    tick();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %b want 0", mem_req_o); end
  endtask

  task automatic test_conflict();
    int n;
    ack_delay = 0;
    ic_addr_i = 32'h104; dm_addr_i = 32'h200; dm_we_i = 1'b0;
    ic_req_i = 1'b1; dm_req_i = 1'b1;
    tick();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h100}) begin errors++; $display("FAIL conflict1_ic_first: got req=%b addr=%h want 1/00000100", mem_req_o, mem_addr_o); end
    n = 0; while (!ic_done_o && n < 20) begin tick(); n++; end
    checks++; if (ic_done_o !== 1'b1) begin errors++; $display("FAIL conflict1_ic_done: got %b want 1", ic_done_o); end
    ic_req_i = 1'b0;
    tick();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h200}) begin errors++; $display("FAIL conflict1_dm_second: got req=%b addr=%h want 1/00000200", mem_req_o, mem_addr_o); end
    n = 0; while (!dm_done_o && n < 20) begin tick(); n++; end
    checks++; if (dm_done_o !== 1'b1) begin errors++; $display("FAIL conflict1_dm_done: got %b want 1", dm_done_o); end
    checks++; if (dm_rdata_o !== 32'hA5A5_0200) begin errors++; $display("FAIL conflict1_dm_rdata: got %h want a5a50200", dm_rdata_o); end
    dm_req_i = 1'b0;
`ifdef MEM_ARB_PERF_EN
    checks++; if (dm_wait_cycles_o !== 32'd7) begin errors++; $display("FAIL perf_dm_wait: got %0d want 7", dm_wait_cycles_o); end
`endif
    tick();
    ic_addr_i = 32'h300; dm_addr_i = 32'h400;
    ic_req_i = 1'b1; dm_req_i = 1'b1;
    tick();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h300}) begin errors++; $display("FAIL conflict2_ic_first: got req=%b addr=%h want 1/00000300", mem_req_o, mem_addr_o); end
    n = 0; while (!ic_done_o && n < 20) begin tick(); n++; end
    checks++; if (ic_done_o !== 1'b1) begin errors++; $display("FAIL conflict2_ic_done: got %b want 1", ic_done_o); end
    ic_req_i = 1'b0;
    tick();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h400}) begin errors++; $display("FAIL conflict2_dm_second: got req=%b addr=%h want 1/00000400", mem_req_o, mem_addr_o); end
    n = 0; while (!dm_done_o && n < 20) begin tick(); n++; end
    checks++; if (dm_rdata_o !== 32'hA5A5_0400 || dm_done_o !== 1'b1) begin errors++; $display("FAIL conflict2_dm_done: got done=%b rdata=%h want 1/a5a50400", dm_done_o, dm_rdata_o); end
    dm_req_i = 1'b0;
`ifdef MEM_ARB_PERF_EN
    checks++; if (conflict_cnt_o !== 32'd2) begin errors++; $display("FAIL perf_conflict: got %0d want 2", conflict_cnt_o); end
`endif
  endtask

  task automatic test_ic_burst();
    logic [31:0] exp_addr;
    logic [1:0]  exp_beat;
    repeat (2) tick();
    ack_delay = 0;
    ic_addr_i = 32'h1234; ic_req_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) begin
        exp_addr = 32'h1230 + 32'(4 * (c - 1));
        checks++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, exp_addr}) begin errors++; $display("FAIL burst_addr c=%0d: got req=%b we=%b be=%h addr=%h want 1/0/f/%h", c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, exp_addr); end
      end else begin
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL burst_req_drop c=%0d: got %b want 0", c, mem_req_o); end
      end
      if (c >= 2 && c <= 5) begin
        exp_beat = 2'(c - 2);
        exp_addr = (32'h1230 + 32'(4 * (c - 2))) ^ 32'hA5A5_0000;
        checks++; if ({ic_rvalid_o, ic_beat_o, ic_rdata_o} !== {1'b1, exp_beat, exp_addr}) begin errors++; $display("FAIL burst_beat c=%0d: got v=%b beat=%0d data=%h want 1/%0d/%h", c, ic_rvalid_o, ic_beat_o, ic_rdata_o, exp_beat, exp_addr); end
      end else begin
        checks++; if (ic_rvalid_o !== 1'b0) begin errors++; $display("FAIL burst_rvalid_idle c=%0d: got %b want 0", c, ic_rvalid_o); end
      end
      checks++; if (ic_done_o !== (c == 6)) begin errors++; $display("FAIL burst_done c=%0d: got %b want %b", c, ic_done_o, (c == 6)); end
      if (c == 6) ic_req_i = 1'b0;
    end
  endtask

  task automatic test_dm_store();
    int pulses;
    repeat (2) tick();
    ack_delay = 3; pulses = 0;
    dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'hDEAD_BEEF; dm_be_i = 4'b0011;
    dm_req_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (dm_done_o) pulses++;
      if (c <= 4) begin
        checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== {1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'b0011}) begin errors++; $display("FAIL store_hold c=%0d: got req=%b we=%b addr=%h wd=%h be=%b", c, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o); end
      end
      if (c == 5) begin
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL store_req_drop: got %b want 0", mem_req_o); end
      end
      if (c == 6) begin
        checks++; if (dm_done_o !== 1'b1) begin errors++; $display("FAIL store_done_latency: got %b want 1", dm_done_o); end
        checks++; if (dm_rdata_o !== 32'hA5A5_0400) begin errors++; $display("FAIL store_rdata_kept: got %h want a5a50400", dm_rdata_o); end
        dm_req_i = 1'b0;
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL store_done_count: got %0d want 1", pulses); end
    dm_we_i = 1'b0; ack_delay = 0;
  endtask

  task automatic test_no_preempt();
    repeat (2) tick();
    ack_delay = 0;
    ic_addr_i = 32'h2000; ic_req_i = 1'b1;
    dm_addr_i = 32'h3000; dm_we_i = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      case (c)
        1, 2, 3, 4: begin
          checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h2000 + 32'(4 * (c - 1))}) begin errors++; $display("FAIL preempt_burst c=%0d: got req=%b we=%b addr=%h", c, mem_req_o, mem_we_o, mem_addr_o); end
          if (c == 2) dm_req_i = 1'b1;
        end
        5, 8: begin
          checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL preempt_gap c=%0d: got req=%b want 0", c, mem_req_o); end
        end
        6: begin
          checks++; if ({ic_done_o, mem_req_o} !== 2'b10) begin errors++; $display("FAIL preempt_bubble: got done=%b req=%b want 1/0", ic_done_o, mem_req_o); end
          ic_req_i = 1'b0;
        end
        7: begin
          checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h3000}) begin errors++; $display("FAIL preempt_dm_start: got req=%b we=%b addr=%h want 1/0/00003000", mem_req_o, mem_we_o, mem_addr_o); end
        end
        default: begin
          checks++; if ({dm_done_o, dm_rdata_o} !== {1'b1, 32'hA5A5_3000}) begin errors++; $display("FAIL preempt_dm_done: got done=%b rdata=%h want 1/a5a53000", dm_done_o, dm_rdata_o); end
          dm_req_i = 1'b0;
        end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    repeat (2) tick();
    ack_delay = 0;
    ic_addr_i = 32'h4000; ic_req_i = 1'b1;
    repeat (3) tick();
    checks++; if ({mem_addr_o, ic_beat_o} !== {32'h4008, 2'd1}) begin errors++; $display("FAIL midreset_third_beat: got addr=%h beat=%0d want 00004008/1", mem_addr_o, ic_beat_o); end
    #2 reset_n_i = 1'b0;
    #1;
    checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin errors++; $display("FAIL midreset_mem: got req=%b addr=%h be=%h", mem_req_o, mem_addr_o, mem_be_o); end
    checks++; if ({ic_rvalid_o, ic_beat_o, ic_rdata_o, ic_done_o, dm_done_o, dm_rdata_o} !== '0) begin errors++; $display("FAIL midreset_outs: got v=%b beat=%0d ird=%h dmrd=%h", ic_rvalid_o, ic_beat_o, ic_rdata_o, dm_rdata_o); end
    ic_req_i = 1'b0;
    repeat (2) tick();
    reset_n_i = 1'b1;
    seen = 0;
    repeat (4) begin tick(); if (ic_done_o) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", seen); end
    dm_addr_i = 32'h44; dm_we_i = 1'b0; dm_req_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) begin
        checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h44}) begin errors++; $display("FAIL postreset_grant: got req=%b addr=%h want 1/00000044", mem_req_o, mem_addr_o); end
      end
      if (c == 3) begin
        checks++; if ({dm_done_o, dm_rdata_o} !== {1'b1, 32'hA5A5_0044}) begin errors++; $display("FAIL postreset_done: got done=%b rdata=%h want 1/a5a50044", dm_done_o, dm_rdata_o); end
        dm_req_i = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_ic_burst();
    test_dm_store();
    test_no_preempt();
    test_reset_mid();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between the instruction-cache refill engine and the data-memory stage.
- Sequences icache line refills as multi-beat bursts and data loads/stores as single beats.
- Sits between the core's memory-side interfaces and the external memory model at riscv_top level.
- Arbitration is round-robin; bursts are never preempted.

Parameters:
- LINE_WORDS, 4, words per icache line; power of two, 2..16.
- ADDR_W, 32, byte-address width.

Ports:
clk_i  in  1  system clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
ic_req_i  in  1  icache refill request, held until ic_done_o
ic_addr_i  in  ADDR_W  refill byte address; low log2(LINE_WORDS)+2 bits ignored
ic_rvalid_o  out  1  refill beat valid
ic_rdata_o  out  32  refill beat data
ic_beat_o  out  log2(LINE_WORDS)  index of current refill beat
ic_done_o  out  1  one-cycle pulse after the last beat
dm_req_i  in  1  data access request, held until dm_done_o
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  ADDR_W  word-aligned byte address
dm_wdata_i  in  32  store data
dm_be_i  in  4  store byte enables
dm_rdata_o  out  32  load data, valid with dm_done_o
dm_done_o  out  1  one-cycle completion pulse
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory byte address
mem_wdata_o  out  32  memory write data
mem_be_o  out  4  memory byte enables
mem_ack_i  in  1  beat accepted/completed; rdata valid same cycle
mem_rdata_i  in  32  memory read data

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = DATA, so the icache wins the first tie. Reset mid-transaction aborts immediately with no done pulse.
- States are IDLE, IC_BURST, DM_ACCESS, DONE.
- IDLE:
  - Only one request asserted: grant it.
  - Both asserted: grant the requester not equal to last_grant, then update last_grant.
  - Grant registers the mem_* outputs; mem_req_o rises the cycle after the grant decision.
- All mem_* outputs are registered and held stable while mem_req_o=1 and mem_ack_i=0. mem_ack_i is ignored when mem_req_o=0.
- IC_BURST:
  - Beat k address = line base + 4k; mem_we_o=0; mem_be_o=4'hF.
  - On each ack: ic_rvalid_o=1 next cycle with the captured data and ic_beat_o=k, and the address advances.
  - mem_req_o stays high between beats; back-to-back acks give one beat per cycle.
  - After the ack of beat LINE_WORDS-1: mem_req_o drops and the state goes to DONE.
- DM_ACCESS: one beat. On ack, mem_rdata_i is captured into dm_rdata_o (loads); for stores dm_rdata_o holds its previous value. Then go to DONE.
- DONE:
  - Pulse ic_done_o or dm_done_o for one cycle, then return to IDLE.
  - A new grant can occur in the cycle after DONE, so there is a one-cycle bubble between transactions.
- Latency (ack on first cycle of req, from request seen in IDLE to done pulse):
  - Data access: 3 cycles.
  - Icache refill: LINE_WORDS+2 cycles.
- A requester deasserting its request mid-transaction is ignored; the transaction runs to completion.
- A requester that keeps its request high through its own done pulse is treated as a new request in IDLE.
- Address arithmetic is modulo 2^ADDR_W. Bursts never cross a line because the base is forced line-aligned.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds 32-bit saturating outputs that clear on reset:
  - ic_wait_cycles_o: cycles with ic_req_i=1 while the icache is not granted.
  - dm_wait_cycles_o: the same for the data requester.
  - conflict_cnt_o: IDLE cycles with both requests asserted.
- These counters are exposed for performance_monitor.
- Undefined: the ports and logic are absent; arbitration is unchanged.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum (IDLE, IC_BURST, DM_ACCESS, DONE)
  - grant_t enum (GRANT_IC, GRANT_DM)
  - LINE_OFFSET_W = log2(LINE_WORDS)+2
- One sub-module, mem_arb_perf_cnt: a saturating counter instantiated three times under MEM_ARB_PERF_EN.

Test Plan:
- ic_req only, ic_addr=0x1234, mem_ack_i tied 1 -> mem_addr_o sequence 0x1230, 0x1234, 0x1238, 0x123C; four ic_rvalid_o beats with ic_beat_o 0..3; ic_done_o 6 cycles after request.
- dm store, addr 0x80, wdata 0xDEADBEEF, be 4'b0011, ack delayed 3 cycles -> mem_* held stable for 4 cycles; dm_done_o pulses once; dm_rdata_o unchanged.
- ic_req and dm_req asserted in the same cycle right after reset -> icache granted first, data granted after the icache DONE; a second simultaneous pair grants the icache again (alternation verified).
- dm_req raised during the second beat of an icache burst -> burst completes uninterrupted; data beat starts after DONE plus the bubble.
- reset_n_i pulsed low during the third icache beat -> all outputs 0 asynchronously, no done pulse; a fresh request afterwards completes normally.
- MEM_ARB_PERF_EN defined, conflict scenario above -> conflict_cnt_o=2; dm_wait_cycles_o equals the measured cycles the data requester waited.
